timer_ctrl: RTL and testbench

- Interval-timer controller that sequences one instance of the team's free-running `counter` module.
- Sequencing is done through the counter's synchronous clear.
- Supports one-shot and periodic modes with a programmable terminal value.
- Produces an expiry tick pulse and a one-shot done flag.
- Serves as the shared timebase for timeout and periodic-event generation in the surrounding datapath.

---
 rtl/timer_ctrl_pkg.sv | 12 +
 rtl/timer_ctrl_if.sv | 25 ++
 rtl/timer_ctrl_counter.sv | 30 +++
 rtl/timer_ctrl.sv | 64 ++++++
 tb/tb_timer_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/timer_ctrl_pkg.sv
// Shared definitions for the interval-timer controller: state encoding and default width.
package timer_ctrl_pkg;

    localparam int TC_BW = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/timer_ctrl_if.sv
// Control/status bundle of the interval timer; master drives requests, slave is the controller.
interface timer_ctrl_if
    import timer_ctrl_pkg::*;
#(
    parameter int BW = TC_BW
);
    logic          start_i;
    logic          stop_i;
    logic          periodic_i;
    logic [BW-1:0] limit_i;
    logic          busy_o;
    logic          done_o;
    logic          tick_o;
    logic [BW-1:0] count_o;

    modport master (
        output start_i, stop_i, periodic_i, limit_i,
        input  busy_o, done_o, tick_o, count_o
    );

    modport slave (
        input  start_i, stop_i, periodic_i, limit_i,
        output busy_o, done_o, tick_o, count_o
    );
endinterface

// File: rtl/timer_ctrl_counter.sv
// Free-running up-counter with async active-low reset and sync active-low clear.
// Latency: count updates one cycle after clear/increment; no backpressure.
module counter #(
    parameter int BW = 8
) (
    input  logic          clk_i,
    input  logic          nrst_i,
    input  logic          nrstSync_i,
    output logic [BW-1:0] count_o
);
    logic [BW-1:0] count_q;
    logic [BW-1:0] count_d;

    always_comb begin
        count_d = count_q + 1'b1;
        if (!nrstSync_i) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/timer_ctrl.sv
// One-shot / periodic interval timer sequencing a counter via its synchronous clear.
// Tick is a same-cycle decode of state and count; no backpressure, stop has priority.
module timer_ctrl
    import timer_ctrl_pkg::*;
#(
    parameter int BW = TC_BW
) (
    input  logic        clk_i,
    input  logic        rst_i,
    timer_ctrl_if.slave bus
);
    state_e        state_q;
    logic [BW-1:0] limit_q;
    logic          periodic_q;
    logic [BW-1:0] count;
    logic          expiry;
    logic          clear;

    assign expiry = (count == limit_q);
    // Counter sits at zero outside RUN, so the first RUN cycle always shows 0.
    assign clear  = (state_q != ST_RUN) | expiry | bus.stop_i;

    counter #(
        .BW(BW)
    ) u_counter (
        .clk_i      (clk_i),
        .nrst_i     (~rst_i),
        .nrstSync_i (~clear),
        .count_o    (count)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            limit_q    <= '0;
            periodic_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.stop_i) begin
                        state_q <= ST_IDLE;
                    end else if (bus.start_i) begin
                        limit_q    <= bus.limit_i;
                        periodic_q <= bus.periodic_i;
                        state_q    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.stop_i) begin
                        state_q <= ST_IDLE;
                    end else if (expiry && !periodic_q) begin
                        state_q <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy_o  = (state_q == ST_RUN);
    assign bus.done_o  = (state_q == ST_DONE);
    assign bus.tick_o  = (state_q == ST_RUN) & expiry & ~bus.stop_i;
    assign bus.count_o = count;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: expected outputs queued per cycle, popped and asserted mid-cycle.
module tb_timer_ctrl;
    logic clk;
    logic rst;

    timer_ctrl_if #(.BW(8)) bus ();

    timer_ctrl #(.BW(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       tick;
        logic [7:0] count;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic drive(input logic st, input logic sp, input logic per, input logic [7:0] lim);
        bus.start_i    = st;
        bus.stop_i     = sp;
        bus.periodic_i = per;
        bus.limit_i    = lim;
    endtask

    task automatic expect_out(input logic b, input logic d, input logic t, input logic [7:0] c);
        exp_t e;
        e.busy  = b;
        e.done  = d;
        e.tick  = t;
        e.count = c;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s: scoreboard empty, observed busy=%0b done=%0b tick=%0b count=%0d",
                   tag, bus.busy_o, bus.done_o, bus.tick_o, bus.count_o);
        end else begin
            e = sb.pop_front();
            checks++;
            assert (bus.busy_o === e.busy) else begin
                errors++;
                $error("FAIL %s busy: observed %0b expected %0b", tag, bus.busy_o, e.busy);
            end
            checks++;
            assert (bus.done_o === e.done) else begin
                errors++;
                $error("FAIL %s done: observed %0b expected %0b", tag, bus.done_o, e.done);
            end
            checks++;
            assert (bus.tick_o === e.tick) else begin
                errors++;
                $error("FAIL %s tick: observed %0b expected %0b", tag, bus.tick_o, e.tick);
            end
            checks++;
            assert (bus.count_o === e.count) else begin
                errors++;
                $error("FAIL %s count: observed %0d expected %0d", tag, bus.count_o, e.count);
            end
        end
    endtask

    // Called at a falling edge: apply inputs, check this cycle's outputs, advance one cycle.
    task automatic cyc(input logic st, input logic sp, input logic per, input logic [7:0] lim,
                       input logic b, input logic d, input logic t, input logic [7:0] c,
                       input string tag);
        drive(st, sp, per, lim);
        expect_out(b, d, t, c);
        #1;
        check_out(tag);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 8'd0);
        @(negedge clk);
        expect_out(1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        check_out("reset");
        @(negedge clk);
        rst = 1'b0;

        // One-shot, limit 3
        cyc(1, 0, 0, 8'd3, 0, 0, 0, 8'd0, "os3_start");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 8'd0, 1, 0, (i == 3), 8'(i), $sformatf("os3_run%0d", i));
        cyc(0, 0, 0, 8'd0, 0, 1, 0, 8'd0, "os3_done0");
        cyc(0, 0, 0, 8'd0, 0, 1, 0, 8'd0, "os3_done1");

        // Periodic, limit 2, restarted from DONE
        cyc(1, 0, 1, 8'd2, 0, 1, 0, 8'd0, "p2_start");
        for (int i = 0; i < 9; i++)
            cyc(0, 0, 0, 8'd9, 1, 0, ((i % 3) == 2), 8'(i % 3), $sformatf("p2_run%0d", i));
        cyc(0, 1, 0, 8'd0, 1, 0, 0, 8'd0, "p2_stop");
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, "p2_idle");

        // Periodic, limit 0: tick every cycle; stop suppresses it
        cyc(1, 0, 1, 8'd0, 0, 0, 0, 8'd0, "p0_start");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 8'd0, 1, 0, 1, 8'd0, $sformatf("p0_run%0d", i));
        cyc(0, 1, 0, 8'd0, 1, 0, 0, 8'd0, "p0_stop");
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, "p0_idle");

        // Periodic, limit 5, stop on the expiry cycle
        cyc(1, 0, 1, 8'd5, 0, 0, 0, 8'd0, "p5_start");
        for (int i = 0; i < 5; i++)
            cyc(0, 0, 0, 8'd0, 1, 0, 0, 8'(i), $sformatf("p5_run%0d", i));
        cyc(0, 1, 0, 8'd0, 1, 0, 0, 8'd5, "p5_stop_at_exp");
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, "p5_idle");

        // One-shot, limit 4, start ignored in RUN; start+stop in DONE
        cyc(1, 0, 0, 8'd4, 0, 0, 0, 8'd0, "os4_start");
        cyc(0, 0, 0, 8'd0, 1, 0, 0, 8'd0, "os4_run0");
        cyc(1, 0, 1, 8'd1, 1, 0, 0, 8'd1, "os4_restart_ign");
        cyc(0, 0, 0, 8'd1, 1, 0, 0, 8'd2, "os4_run2");
        cyc(0, 0, 0, 8'd1, 1, 0, 0, 8'd3, "os4_run3");
        cyc(0, 0, 0, 8'd1, 1, 0, 1, 8'd4, "os4_exp");
        cyc(1, 1, 0, 8'd2, 0, 1, 0, 8'd0, "os4_done_ss");
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, "os4_idle");

        // One-shot, limit 0: tick on first RUN cycle then DONE; stop clears done
        cyc(1, 0, 0, 8'd0, 0, 0, 0, 8'd0, "os0_start");
        cyc(0, 0, 0, 8'd0, 1, 0, 1, 8'd0, "os0_exp");
        cyc(1, 1, 0, 8'd0, 0, 1, 0, 8'd0, "os0_done_stop");
        cyc(0, 0, 0, 8'd0, 0, 0, 0, 8'd0, "os0_idle");

        // Periodic, limit 7, asynchronous reset at count 4
        cyc(1, 0, 1, 8'd7, 0, 0, 0, 8'd0, "p7_start");
        for (int i = 0; i < 4; i++)
            cyc(0, 0, 0, 8'd0, 1, 0, 0, 8'(i), $sformatf("p7_run%0d", i));
        expect_out(1'b1, 1'b0, 1'b0, 8'd4);
        #1;
        check_out("p7_run4");
        #2;
        rst = 1'b1;
        expect_out(1'b0, 1'b0, 1'b0, 8'd0);
        #1;
        check_out("p7_async_rst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 1, 8'd7, 0, 0, 0, 8'd0, $sformatf("p7_post_rst%0d", i));

        // One-shot, full-range limit 255
        cyc(1, 0, 0, 8'd255, 0, 0, 0, 8'd0, "full_start");
        for (int i = 0; i < 256; i++)
            cyc(0, 0, 0, 8'd0, 1, 0, (i == 255), 8'(i), $sformatf("full_run%0d", i));
        cyc(0, 0, 0, 8'd0, 0, 1, 0, 8'd0, "full_done");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
